pdp_mem_ctrl: RTL and testbench

Parametrised multi-channel memory controller for the PDP-8 pipeline. It replaces the separate fetch-read, execute-read and execute-write memory paths with N_CH request channels arbitrated onto one single-port memory array of DEPTH words. Arbitration is fixed priority or round-robin. Sits between instr_decode/instr_exec and main memory. Its per-channel wait signals drive pipeline stall.

---
 rtl/pdp_mem_pkg.sv | 24 ++
 rtl/pdp_mem_ctrl_if.sv | 40 ++++
 rtl/pdp_rr_arbiter.sv | 62 ++++++
 rtl/pdp_mem_ctrl.sv | 114 +++++++++++
 tb/tb_pdp_mem_ctrl.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pdp_mem_pkg.sv
// pdp_mem_pkg
// Shared constants and types for the PDP-8 multi-channel memory controller.
// Holds the standard word/address widths, the channel index assignment of the
// standard three-channel build, and the request bundle a requester prepares
// before it raises req.
package pdp_mem_pkg;

  localparam int PDP_ADDR_WIDTH = 12;
  localparam int PDP_DATA_WIDTH = 12;
  localparam int PDP_N_CH       = 3;

  // Channel roles in the standard build
  localparam int CH_FETCH   = 0;
  localparam int CH_EXEC_RD = 1;
  localparam int CH_EXEC_WR = 2;

  // One requester's access: direction, word address and write data
  typedef struct packed {
    logic                      we;
    logic [PDP_ADDR_WIDTH-1:0] addr;
    logic [PDP_DATA_WIDTH-1:0] wdata;
  } pdp_mem_req_s;

endpackage

// File: rtl/pdp_mem_ctrl_if.sv
// pdp_mem_ctrl_if
// Request/grant/read-data bundle between the pipeline requesters and
// pdp_mem_ctrl.
//   req      per-channel access request
//   we       per-channel write enable (1 = write)
//   addr     packed addresses, channel i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   wdata    packed write data, same packing
//   gnt      one-hot combinational grant
//   wait_o   req & ~gnt, drives pipeline stall
//   rd_valid one-cycle pulse marking read data for channel i
//   rd_data  shared registered read-data bus
// Modports: master (requester side), slave (controller side).
interface pdp_mem_ctrl_if
  import pdp_mem_pkg::*;
#(
  parameter int N_CH       = PDP_N_CH,
  parameter int ADDR_WIDTH = PDP_ADDR_WIDTH,
  parameter int DATA_WIDTH = PDP_DATA_WIDTH
);

  logic [N_CH-1:0]            req;
  logic [N_CH-1:0]            we;
  logic [N_CH*ADDR_WIDTH-1:0] addr;
  logic [N_CH*DATA_WIDTH-1:0] wdata;
  logic [N_CH-1:0]            gnt;
  logic [N_CH-1:0]            wait_o;
  logic [N_CH-1:0]            rd_valid;
  logic [DATA_WIDTH-1:0]      rd_data;

  modport master (
    output req, we, addr, wdata,
    input  gnt, wait_o, rd_valid, rd_data
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, wait_o, rd_valid, rd_data
  );

endinterface

// File: rtl/pdp_rr_arbiter.sv
// pdp_rr_arbiter
// Picks one requesting channel per cycle and returns a one-hot grant.
// Build option: PDP_MEM_RR_ARB_EN
//   defined   - round-robin; the search starts at ptr_i and next_ptr_o is the
//               channel after the winner (or ptr_i when nothing is granted)
//   undefined - fixed priority, lowest index wins; no pointer ports exist
// Ports:
//   req_i       per-channel request
//   ptr_i       current round-robin start channel (round-robin build only)
//   gnt_o       one-hot grant, all zero when req_i is zero
//   next_ptr_o  pointer value for the next cycle (round-robin build only)
module pdp_rr_arbiter #(
  parameter int N_CH  = 3,
  parameter int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic [N_CH-1:0]  req_i,
`ifdef PDP_MEM_RR_ARB_EN
  input  logic [PTR_W-1:0] ptr_i,
  output logic [PTR_W-1:0] next_ptr_o,
`endif
  output logic [N_CH-1:0]  gnt_o
);

  logic found;

`ifdef PDP_MEM_RR_ARB_EN
  int idx;
  int winner;

  // Walk the channels in circular order starting at the pointer; the first
  // requester met wins, so every waiting channel is reached within N_CH grants.
  always_comb begin
    gnt_o  = '0;
    found  = 1'b0;
    idx    = 0;
    winner = 0;
    for (int k = 0; k < N_CH; k++) begin
      idx = (int'(ptr_i) + k) % N_CH;
      if (req_i[idx] && !found) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
        winner     = idx;
      end
    end
    next_ptr_o = found ? PTR_W'((winner + 1) % N_CH) : ptr_i;
  end
`else
  // Fixed priority: the lowest requesting index wins, so fetch always
  // beats the execute channels.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (req_i[i] && !found) begin
        gnt_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/pdp_mem_ctrl.sv
// pdp_mem_ctrl
// Multi-channel memory controller for the PDP-8 pipeline. N_CH requesters
// share one single-port array of DEPTH words; one access commits per clock.
// Build option: PDP_MEM_RR_ARB_EN selects round-robin arbitration (with a
// registered pointer); without it fixed priority is used and no pointer exists.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      pdp_mem_ctrl_if.slave: req/we/addr/wdata in,
//            gnt/wait_o/rd_valid/rd_data out
// Addresses wrap modulo DEPTH (low log2(DEPTH) bits). Memory is not reset.
module pdp_mem_ctrl
  import pdp_mem_pkg::*;
#(
  parameter int N_CH       = PDP_N_CH,
  parameter int ADDR_WIDTH = PDP_ADDR_WIDTH,
  parameter int DATA_WIDTH = PDP_DATA_WIDTH,
  parameter int DEPTH      = 4096
) (
  input logic          clk,
  input logic          reset_n,
  pdp_mem_ctrl_if.slave bus
);

  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0]       gnt;
  logic                  anyGnt;
  logic                  selWe;
  logic [MEM_AW-1:0]     selAddr;
  logic [DATA_WIDTH-1:0] selWdata;
  logic                  memWe;
  logic [N_CH-1:0]       rdValid_d;
  logic [N_CH-1:0]       rdValid_q;
  logic [DATA_WIDTH-1:0] rdData_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef PDP_MEM_RR_ARB_EN
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  pdp_rr_arbiter #(.N_CH(N_CH), .PTR_W(PTR_W)) u_arb (
    .req_i      (bus.req),
    .ptr_i      (ptr_q),
    .next_ptr_o (ptr_d),
    .gnt_o      (gnt)
  );

  // Round-robin pointer; the arbiter already holds it when nothing is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  pdp_rr_arbiter #(.N_CH(N_CH), .PTR_W(PTR_W)) u_arb (
    .req_i (bus.req),
    .gnt_o (gnt)
  );
`endif

  // Route the winning channel's command onto the memory port. Only the low
  // MEM_AW address bits are taken, which is what makes addresses wrap.
  always_comb begin
    selWe    = 1'b0;
    selAddr  = '0;
    selWdata = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (gnt[i]) begin
        selWe    = bus.we[i];
        selAddr  = bus.addr[i*ADDR_WIDTH +: MEM_AW];
        selWdata = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Write strobe is qualified by reset_n so an edge seen while in reset never
  // changes memory; a granted read marks its channel for the valid pulse.
  always_comb begin
    anyGnt    = |gnt;
    memWe     = anyGnt && selWe && reset_n;
    rdValid_d = (anyGnt && !selWe) ? gnt : '0;
  end

  // Memory array: not reset, one write port.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[selAddr] <= selWdata;
    end
  end

  // Registered read data and valid pulse. A read granted right after a write
  // to the same word sees the new value since the write landed an edge earlier.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdValid_q <= '0;
      rdData_q  <= '0;
    end else begin
      rdValid_q <= rdValid_d;
      if (anyGnt && !selWe) begin
        rdData_q <= mem[selAddr];
      end
    end
  end

  assign bus.gnt      = gnt;
  assign bus.wait_o   = bus.req & ~gnt;
  assign bus.rd_valid = rdValid_q;
  assign bus.rd_data  = rdData_q;

endmodule

// File: tb/tb_pdp_mem_ctrl.sv
// tb_pdp_mem_ctrl
// Self-checking bench for pdp_mem_ctrl (3 channels, 12-bit words, DEPTH=256
// so that address wrap can be exercised). A behavioural model holds the memory
// image, the arbitration rule and the expected read pulse. Builds with or
// without PDP_MEM_RR_ARB_EN.
module tb_pdp_mem_ctrl;
  import pdp_mem_pkg::*;

  localparam int NCH = 3;
  localparam int AW  = 12;
  localparam int DW  = 12;
  localparam int DEP = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b1;

  always #5 clk = ~clk;

  pdp_mem_ctrl_if #(.N_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  pdp_mem_ctrl #(.N_CH(NCH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEP)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int compared = 0;
  int mismatched = 0;

  pdp_mem_req_s   chReq [NCH];
  logic [NCH-1:0] chValid;
  logic [NCH-1:0] expGnt;
  logic [NCH-1:0] expRdValid;
  logic [DW-1:0]  expRdData;
  logic [DW-1:0]  modelMem [DEP];
  int             modelPtr;
  bit             inReset;

  // Arbitration rule: scan channels circularly from the start point.
  function automatic logic [NCH-1:0] modelArb(input logic [NCH-1:0] r);
    logic [NCH-1:0] g;
    int start;
    int idx;
    g = '0;
`ifdef PDP_MEM_RR_ARB_EN
    start = modelPtr;
`else
    start = 0;
`endif
    for (int k = 0; k < NCH; k++) begin
      idx = (start + k) % NCH;
      if (r[idx] && g == '0) g[idx] = 1'b1;
    end
    return g;
  endfunction

  task automatic setCh(input int i, input bit v, input bit w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    chValid[i]     = v;
    chReq[i].we    = w;
    chReq[i].addr  = a;
    chReq[i].wdata = d;
  endtask

  task automatic idleAll();
    chValid = '0;
    for (int i = 0; i < NCH; i++) chReq[i] = '0;
  endtask

  // Drive the channel table onto the bus and predict this cycle's grant.
  task automatic applyStimulus();
    logic [NCH*AW-1:0] a;
    logic [NCH*DW-1:0] d;
    logic [NCH-1:0]    w;
    for (int i = 0; i < NCH; i++) begin
      w[i]           = chReq[i].we;
      a[i*AW +: AW]  = chReq[i].addr;
      d[i*DW +: DW]  = chReq[i].wdata;
    end
    bus.req   = chValid;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = d;
    expGnt    = modelArb(chValid);
    #1;
  endtask

  // Advance one clock and commit the granted access into the model.
  task automatic clockEdge();
    int w;
    @(posedge clk);
    if (!inReset) begin
      expRdValid = '0;
      if (expGnt != '0) begin
        w = 0;
        for (int i = 0; i < NCH; i++) if (expGnt[i]) w = i;
        if (chReq[w].we) begin
          modelMem[int'(chReq[w].addr) % DEP] = chReq[w].wdata;
        end else begin
          expRdData  = modelMem[int'(chReq[w].addr) % DEP];
          expRdValid = expGnt;
        end
        modelPtr = (w + 1) % NCH;
      end
    end
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    inReset = 1'b1;
    modelPtr = 0;
    expRdValid = '0;
    expRdData = '0;
    idleAll();
    applyStimulus();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    inReset = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    inReset = 1'b1;
    modelPtr = 0;
    expRdValid = '0;
    expRdData = '0;
    idleAll();
    applyStimulus();
    compared++; if (bus.gnt !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_gnt: got %b want 000", bus.gnt); end
    compared++; if (bus.wait_o !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_wait: got %b want 000", bus.wait_o); end
    compared++; if (bus.rd_valid !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_rd_valid: got %b want 000", bus.rd_valid); end
    compared++; if (bus.rd_data !== 12'o0) begin mismatched++; $display("[TB] FAIL reset_rd_data: got %o want 0", bus.rd_data); end
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    inReset = 1'b0;
  endtask

  // Give every word a known value through the write channel.
  task automatic test_fill();
    for (int a = 0; a < DEP; a++) begin
      idleAll();
      setCh(CH_EXEC_WR, 1'b1, 1'b1, AW'(a), DW'($urandom));
      applyStimulus();
      compared++; if (bus.gnt !== 3'b100) begin mismatched++; $display("[TB] FAIL fill_gnt: got %b want 100", bus.gnt); end
      clockEdge();
    end
  endtask

  task automatic test_single_read();
    idleAll();
    setCh(CH_FETCH, 1'b1, 1'b1, 12'o200, 12'o7402);
    applyStimulus();
    clockEdge();
    idleAll();
    setCh(CH_FETCH, 1'b1, 1'b0, 12'o200, 12'o0);
    applyStimulus();
    compared++; if (bus.gnt !== 3'b001) begin mismatched++; $display("[TB] FAIL single_gnt: got %b want 001", bus.gnt); end
    compared++; if (bus.wait_o !== 3'b000) begin mismatched++; $display("[TB] FAIL single_wait: got %b want 000", bus.wait_o); end
    clockEdge();
    compared++; if (bus.rd_valid !== 3'b001) begin mismatched++; $display("[TB] FAIL single_rd_valid: got %b want 001", bus.rd_valid); end
    compared++; if (bus.rd_data !== 12'o7402) begin mismatched++; $display("[TB] FAIL single_rd_data: got %o want 7402", bus.rd_data); end
    idleAll();
    applyStimulus();
    clockEdge();
    compared++; if (bus.rd_valid !== 3'b000) begin mismatched++; $display("[TB] FAIL single_pulse_end: got %b want 000", bus.rd_valid); end
  endtask

  task automatic test_write_then_read();
    idleAll();
    setCh(CH_EXEC_WR, 1'b1, 1'b1, 12'o50, 12'o1234);
    applyStimulus();
    compared++; if (bus.gnt !== 3'b100) begin mismatched++; $display("[TB] FAIL wr_gnt: got %b want 100", bus.gnt); end
    clockEdge();
    compared++; if (bus.rd_valid !== 3'b000) begin mismatched++; $display("[TB] FAIL wr_no_valid: got %b want 000", bus.rd_valid); end
    idleAll();
    setCh(CH_EXEC_RD, 1'b1, 1'b0, 12'o50, 12'o0);
    applyStimulus();
    compared++; if (bus.gnt !== 3'b010) begin mismatched++; $display("[TB] FAIL raw_gnt: got %b want 010", bus.gnt); end
    clockEdge();
    compared++; if (bus.rd_valid !== 3'b010) begin mismatched++; $display("[TB] FAIL raw_rd_valid: got %b want 010", bus.rd_valid); end
    compared++; if (bus.rd_data !== 12'o1234) begin mismatched++; $display("[TB] FAIL raw_rd_data: got %o want 1234", bus.rd_data); end
  endtask

  task automatic test_wrap();
    idleAll();
    setCh(CH_EXEC_WR, 1'b1, 1'b1, 12'o400, 12'o77);
    applyStimulus();
    clockEdge();
    idleAll();
    setCh(CH_EXEC_RD, 1'b1, 1'b0, 12'o0, 12'o0);
    applyStimulus();
    clockEdge();
    compared++; if (bus.rd_valid !== 3'b010) begin mismatched++; $display("[TB] FAIL wrap_rd_valid: got %b want 010", bus.rd_valid); end
    compared++; if (bus.rd_data !== 12'o77) begin mismatched++; $display("[TB] FAIL wrap_rd_data0: got %o want 77", bus.rd_data); end
    idleAll();
    setCh(CH_FETCH, 1'b1, 1'b0, 12'o7400, 12'o0);
    applyStimulus();
    clockEdge();
    compared++; if (bus.rd_data !== 12'o77) begin mismatched++; $display("[TB] FAIL wrap_rd_data_hi: got %o want 77", bus.rd_data); end
  endtask

  task automatic test_contention();
    logic [NCH-1:0] want;
    doReset();
    idleAll();
    for (int i = 0; i < NCH; i++) setCh(i, 1'b1, 1'b0, AW'(i + 1), 12'o0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus();
`ifdef PDP_MEM_RR_ARB_EN
      want = 3'b001 << (c % 3);
`else
      want = 3'b001;
`endif
      compared++; if (bus.gnt !== want) begin mismatched++; $display("[TB] FAIL contend_gnt[%0d]: got %b want %b", c, bus.gnt, want); end
      compared++; if (bus.wait_o !== (3'b111 & ~want)) begin mismatched++; $display("[TB] FAIL contend_wait[%0d]: got %b want %b", c, bus.wait_o, 3'b111 & ~want); end
      compared++; if (bus.rd_valid !== expRdValid) begin mismatched++; $display("[TB] FAIL contend_rd_valid[%0d]: got %b want %b", c, bus.rd_valid, expRdValid); end
      compared++; if (bus.rd_data !== expRdData) begin mismatched++; $display("[TB] FAIL contend_rd_data[%0d]: got %o want %o", c, bus.rd_data, expRdData); end
      clockEdge();
    end
  endtask

  task automatic test_reset_mid_read();
    idleAll();
    setCh(CH_EXEC_RD, 1'b1, 1'b0, 12'o50, 12'o0);
    applyStimulus();
    compared++; if (bus.gnt !== 3'b010) begin mismatched++; $display("[TB] FAIL mid_gnt: got %b want 010", bus.gnt); end
    clockEdge();
    reset_n = 1'b0;
    inReset = 1'b1;
    modelPtr = 0;
    expRdValid = '0;
    expRdData = '0;
    idleAll();
    setCh(CH_EXEC_WR, 1'b1, 1'b1, 12'o50, 12'o5555);
    applyStimulus();
    compared++; if (bus.rd_valid !== 3'b000) begin mismatched++; $display("[TB] FAIL mid_rd_valid: got %b want 000", bus.rd_valid); end
    compared++; if (bus.rd_data !== 12'o0) begin mismatched++; $display("[TB] FAIL mid_rd_data: got %o want 0", bus.rd_data); end
    compared++; if (bus.gnt !== 3'b100) begin mismatched++; $display("[TB] FAIL mid_gnt_in_reset: got %b want 100", bus.gnt); end
    clockEdge();
    clockEdge();
    compared++; if (bus.rd_valid !== 3'b000) begin mismatched++; $display("[TB] FAIL mid_rd_valid_held: got %b want 000", bus.rd_valid); end
    reset_n = 1'b1;
    inReset = 1'b0;
    idleAll();
    for (int i = 0; i < NCH; i++) setCh(i, 1'b1, 1'b0, AW'(i + 8), 12'o0);
    applyStimulus();
    compared++; if (bus.gnt !== 3'b001) begin mismatched++; $display("[TB] FAIL mid_ptr_zero: got %b want 001", bus.gnt); end
    clockEdge();
    idleAll();
    setCh(CH_EXEC_RD, 1'b1, 1'b0, 12'o50, 12'o0);
    applyStimulus();
    clockEdge();
    compared++; if (bus.rd_data !== 12'o1234) begin mismatched++; $display("[TB] FAIL mid_no_write: got %o want 1234", bus.rd_data); end
  endtask

  task automatic test_idle();
    logic [AW-1:0] addrs [3];
    logic [DW-1:0] vals [3];
    addrs[0] = 12'o50;  vals[0] = 12'o1234;
    addrs[1] = 12'o200; vals[1] = 12'o7402;
    addrs[2] = 12'o0;   vals[2] = 12'o77;
    idleAll();
    for (int c = 0; c < 10; c++) begin
      applyStimulus();
      compared++; if (bus.gnt !== 3'b000) begin mismatched++; $display("[TB] FAIL idle_gnt[%0d]: got %b want 000", c, bus.gnt); end
      compared++; if (bus.wait_o !== 3'b000) begin mismatched++; $display("[TB] FAIL idle_wait[%0d]: got %b want 000", c, bus.wait_o); end
      clockEdge();
      compared++; if (bus.rd_valid !== 3'b000) begin mismatched++; $display("[TB] FAIL idle_rd_valid[%0d]: got %b want 000", c, bus.rd_valid); end
    end
    for (int k = 0; k < 3; k++) begin
      idleAll();
      setCh(CH_FETCH, 1'b1, 1'b0, addrs[k], 12'o0);
      applyStimulus();
      clockEdge();
      compared++; if (bus.rd_data !== vals[k]) begin mismatched++; $display("[TB] FAIL idle_mem[%0d]: got %o want %o", k, bus.rd_data, vals[k]); end
    end
  endtask

  // Randomised traffic: each channel holds its request until granted, then
  // may issue a new one; everything is checked against the model every cycle.
  task automatic test_random();
    int waitCnt [NCH];
    idleAll();
    for (int i = 0; i < NCH; i++) waitCnt[i] = 0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      for (int i = 0; i < NCH; i++) begin
        if (!chValid[i] && $urandom_range(0, 99) < 55) begin
          setCh(i, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
          waitCnt[i] = 0;
        end
      end
      applyStimulus();
      compared++; if (bus.gnt !== expGnt) begin mismatched++; $display("[TB] FAIL rand_gnt[%0d]: got %b want %b", cyc, bus.gnt, expGnt); end
      compared++; if (bus.wait_o !== (chValid & ~expGnt)) begin mismatched++; $display("[TB] FAIL rand_wait[%0d]: got %b want %b", cyc, bus.wait_o, chValid & ~expGnt); end
      compared++; if (bus.rd_valid !== expRdValid) begin mismatched++; $display("[TB] FAIL rand_rd_valid[%0d]: got %b want %b", cyc, bus.rd_valid, expRdValid); end
      compared++; if (bus.rd_data !== expRdData) begin mismatched++; $display("[TB] FAIL rand_rd_data[%0d]: got %o want %o", cyc, bus.rd_data, expRdData); end
      clockEdge();
      for (int i = 0; i < NCH; i++) begin
        if (chValid[i] && !bus.gnt[i]) waitCnt[i]++;
`ifdef PDP_MEM_RR_ARB_EN
        if (chValid[i]) begin
          compared++;
          if (waitCnt[i] >= NCH) begin mismatched++; $display("[TB] FAIL rand_starve[%0d]: ch %0d waited %0d want < %0d", cyc, i, waitCnt[i], NCH); end
        end
`endif
      end
      chValid = chValid & ~expGnt;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    idleAll();
    expGnt = '0;
    expRdValid = '0;
    expRdData = '0;
    modelPtr = 0;
    inReset = 1'b0;
    bus.req = '0;
    bus.we = '0;
    bus.addr = '0;
    bus.wdata = '0;
    #2;
    test_reset();
    test_fill();
    test_single_read();
    test_write_then_read();
    test_wrap();
    test_contention();
    test_reset_mid_read();
    test_idle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
